// File: rtl/gate_test_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : gate_test_sequencer_if
//  Description : Stimulus/response and result bundle between the gate test
//                sequencer (master) and the gates under test plus the
//                result observer (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface gate_test_sequencer_if #(
  parameter int WIDTH   = 2,
  parameter int NUM_DUT = 4
);
  logic                 start;
  logic [NUM_DUT-1:0]   dut_rsp;
  logic [WIDTH-1:0]     stimulus;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [NUM_DUT-1:0]   err_mask;
  logic [7:0]           err_count;

  // Sequencer side: drives stimulus and results, receives run request and responses
  modport master (
    input  start, dut_rsp,
    output stimulus, busy, done, pass, err_mask, err_count
  );

  // Environment side: requests runs, returns gate responses, observes results
  modport slave (
    output start, dut_rsp,
    input  stimulus, busy, done, pass, err_mask, err_count
  );
endinterface
`default_nettype wire

// File: rtl/gate_test_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : gate_test_sequencer
//  Description : Clocked stimulus controller for the gate-under-test datapath.
//                Steps a shared stimulus bus through every combination, holds
//                each vector for a settle window, checks every DUT response
//                against an XOR or AND golden reduction, and accumulates a
//                sticky per-DUT failure mask and a saturating mismatch count.
//  Revision    : 1.0 - initial release
// ============================================================================
module gate_test_sequencer #(
  parameter int                 WIDTH    = 2,
  parameter int                 NUM_DUT  = 4,
  parameter int                 SETTLE   = 1,
  parameter logic [NUM_DUT-1:0] GOLD_SEL = NUM_DUT'(4'b1010)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  gate_test_sequencer_if.master bus
);

  // Counter only has to hold SETTLE-1; keep at least one bit.
  localparam int                 CNT_W      = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0]   CNT_RELOAD = CNT_W'(SETTLE - 1);
  localparam logic [WIDTH-1:0]   STIM_LAST  = '1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_CHECK  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [1:0]         state_q,     state_d;
  logic [WIDTH-1:0]   stim_q,      stim_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic               pass_q,      pass_d;
  logic [NUM_DUT-1:0] err_mask_q,  err_mask_d;
  logic [7:0]         err_count_q, err_count_d;

  logic               gold_xor;
  logic               gold_and;
  logic [NUM_DUT-1:0] expected;
  logic [NUM_DUT-1:0] mismatch;
  logic [15:0]        popcnt;
  logic [15:0]        count_sum;
  logic [7:0]         count_sat;

  assign gold_xor = ^stim_q;
  assign gold_and = &stim_q;

  // Each DUT is judged against the reduction selected by its GOLD_SEL bit.
  for (genvar i = 0; i < NUM_DUT; i++) begin : g_expected
    assign expected[i] = GOLD_SEL[i] ? gold_xor : gold_and;
  end

  assign mismatch = bus.dut_rsp ^ expected;

  // Count mismatching DUT bits in this vector and saturate the running total.
  always_comb begin
    popcnt = '0;
    for (int i = 0; i < NUM_DUT; i++) begin
      popcnt = popcnt + 16'(mismatch[i]);
    end
    count_sum = 16'(err_count_q) + popcnt;
    count_sat = (count_sum > 16'd255) ? 8'hFF : count_sum[7:0];
  end

  // Next-state logic for the run sequencer; responses only matter in CHECK.
  always_comb begin
    state_d     = state_q;
    stim_d      = stim_q;
    cnt_d       = cnt_q;
    pass_d      = pass_q;
    err_mask_d  = err_mask_q;
    err_count_d = err_count_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          err_mask_d  = '0;
          err_count_d = '0;
          pass_d      = 1'b0;
          stim_d      = '0;
          cnt_d       = CNT_RELOAD;
          state_d     = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = ST_CHECK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_CHECK: begin
        err_mask_d  = err_mask_q | mismatch;
        err_count_d = count_sat;
        if (stim_q == STIM_LAST) begin
          state_d = ST_DONE;
        end else begin
          stim_d  = stim_q + 1'b1;
          cnt_d   = CNT_RELOAD;
          state_d = ST_SETTLE;
        end
      end
      ST_DONE: begin
        // err_count already includes the final CHECK at this point.
        pass_d  = (err_count_q == 8'd0);
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset that aborts any run in progress.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      stim_q      <= '0;
      cnt_q       <= '0;
      pass_q      <= 1'b0;
      err_mask_q  <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      stim_q      <= stim_d;
      cnt_q       <= cnt_d;
      pass_q      <= pass_d;
      err_mask_q  <= err_mask_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.stimulus  = stim_q;
  assign bus.busy      = (state_q == ST_SETTLE) || (state_q == ST_CHECK);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.pass      = pass_q;
  assign bus.err_mask  = err_mask_q;
  assign bus.err_count = err_count_q;

endmodule
`default_nettype wire
